// File: rtl/rf_wb_scheduler.sv
// Writeback scheduler for a 4x16 register file: round-robin arbitration of two
// writeback requesters onto the single write port, plus a pending-write scoreboard.
module rf_wb_scheduler #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 2,
    parameter int unsigned CNT_W  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [IDX_W-1:0]      a_index,
    input  logic [DATA_W-1:0]     a_data,
    output logic                  a_ready,
    input  logic                  b_valid,
    input  logic [IDX_W-1:0]      b_index,
    input  logic [DATA_W-1:0]     b_data,
    output logic                  b_ready,
    input  logic                  rsv_valid,
    input  logic [IDX_W-1:0]      rsv_index,
    output logic                  rsv_ready,
    input  logic                  rd_en1,
    input  logic                  rd_en2,
    input  logic [IDX_W-1:0]      rd_index1,
    input  logic [IDX_W-1:0]      rd_index2,
    output logic                  rd_stall,
    output logic                  wr_enable,
    output logic [IDX_W-1:0]      wr_index,
    output logic [DATA_W-1:0]     wr_data,
    output logic [2**IDX_W-1:0]   pending,
    output logic                  last_grant,
    output logic                  wb_orphan
);

    localparam int unsigned NREG = 2**IDX_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    typedef struct packed {
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } wb_req_t;

    logic [CNT_W-1:0] cnt_q [NREG];
    logic [CNT_W-1:0] cnt_d [NREG];
    logic             grant_a;
    logic             grant_b;
    logic             wb_fire;
    logic             rsv_fire;
    logic             orphan_hit;
    wb_req_t          wb_sel;
    logic [NREG-1:0]  rsv_hit;
    logic [NREG-1:0]  wb_hit;

    // Round-robin: on contention the requester that did not win last time is granted
    always_comb begin
        grant_a     = a_valid & (~b_valid | last_grant);
        grant_b     = b_valid & (~a_valid | ~last_grant);
        wb_fire     = grant_a | grant_b;
        wb_sel.idx  = grant_b ? b_index : a_index;
        wb_sel.data = grant_b ? b_data  : a_data;
    end

    assign a_ready    = grant_a;
    assign b_ready    = grant_b;
    assign rsv_ready  = (cnt_q[rsv_index] != CNT_MAX);
    assign rsv_fire   = rsv_valid & rsv_ready;
    assign orphan_hit = wb_fire & (cnt_q[wb_sel.idx] == '0);

    // Per-register count update; a reservation and a write to the same register cancel
    always_comb begin
        rsv_hit = '0;
        wb_hit  = '0;
        for (int i = 0; i < NREG; i++) begin
            rsv_hit[i] = rsv_fire & (rsv_index == IDX_W'(i));
            wb_hit[i]  = wb_fire & (wb_sel.idx == IDX_W'(i));
            cnt_d[i]   = cnt_q[i];
            if (rsv_hit[i] && !wb_hit[i]) begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end else if (wb_hit[i] && !rsv_hit[i] && (cnt_q[i] != '0)) begin
                cnt_d[i] = cnt_q[i] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        pending = '0;
        for (int i = 0; i < NREG; i++) begin
            pending[i] = (cnt_q[i] != '0);
        end
    end

    // Stall uses current counts only; a write accepted now releases it next cycle
    assign rd_stall = (rd_en1 & pending[rd_index1]) | (rd_en2 & pending[rd_index2]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_enable  <= 1'b0;
            wr_index   <= '0;
            wr_data    <= '0;
            last_grant <= 1'b1;
            wb_orphan  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            wr_enable <= wb_fire;
            if (wb_fire) begin
                wr_index   <= wb_sel.idx;
                wr_data    <= wb_sel.data;
                last_grant <= grant_b;
            end
            if (orphan_hit) begin
                wb_orphan <= 1'b1;
            end
            for (int i = 0; i < NREG; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

endmodule
